// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types for the 7-segment display path
package display_pkg;

    // Multiplexer phase. BLANK states keep both anodes dark between digits.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIG0   = 3'd1,
        BLANK0 = 3'd2,
        DIG1   = 3'd3,
        BLANK1 = 3'd4
    } state_t;

    // One hex digit on the shared digit bus.
    typedef logic [3:0] digit_t;

endpackage

// File: rtl/display_mux.sv
// rtl/display_mux.sv - two-digit time multiplexer with blanking and registered sum
//
// Purpose: alternates digits a and b onto the shared digit bus s, driving one
// active-low anode enable per digit, with an optional dark gap between digits.
// Also registers a + b for the LED bank.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low reset
//   a      - digit 0 value (left display)
//   b      - digit 1 value (right display)
//   s      - digit value to display_controller
//   en0_n  - anode enable digit 0, active-low
//   en1_n  - anode enable digit 1, active-low
//   sum    - registered a + b
module display_mux
    import display_pkg::*;
#(
    parameter int DIG_CYCLES   = 4096,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  digit_t     a,
    input  digit_t     b,
    output digit_t     s,
    output logic       en0_n,
    output logic       en1_n,
    output logic [4:0] sum
);

    localparam int MAX_CYCLES = (DIG_CYCLES > BLANK_CYCLES) ? DIG_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] DIG_LAST   = CNT_W'(DIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    // With no blanking the DIG states hand over directly to each other.
    localparam state_t AFTER_DIG0 = (BLANK_CYCLES == 0) ? DIG1 : BLANK0;
    localparam state_t AFTER_DIG1 = (BLANK_CYCLES == 0) ? DIG0 : BLANK1;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    digit_t           r_dreg;
    logic [4:0]       r_sum;
    logic             w_enter_dig0;
    logic             w_enter_dig1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = DIG0;
            DIG0:    if (r_cnt == DIG_LAST)   w_next = AFTER_DIG0;
            BLANK0:  if (r_cnt == BLANK_LAST) w_next = DIG1;
            DIG1:    if (r_cnt == DIG_LAST)   w_next = AFTER_DIG1;
            BLANK1:  if (r_cnt == BLANK_LAST) w_next = DIG0;
            default: w_next = IDLE;
        endcase
    end

    // The digit register only samples on entry, so input changes during a
    // phase wait until that digit is next selected.
    assign w_enter_dig0 = (w_next == DIG0) && (r_state != DIG0);
    assign w_enter_dig1 = (w_next == DIG1) && (r_state != DIG1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dreg  <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            if (w_enter_dig0) begin
                r_dreg <= a;
            end else if (w_enter_dig1) begin
                r_dreg <= b;
            end
            r_sum <= {1'b0, a} + {1'b0, b};
        end
    end

    // Enables decode from a single registered state, so both can never be low.
    assign s     = r_dreg;
    assign en0_n = (r_state != DIG0);
    assign en1_n = (r_state != DIG1);
    assign sum   = r_sum;

endmodule

// File: tb/tb_display_mux.sv
// tb/tb_display_mux.sv - scoreboard bench for display_mux
module tb_display_mux;
    import display_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    digit_t     a, b;
    digit_t     s, ns;
    logic       en0_n, en1_n, nen0_n, nen1_n;
    logic [4:0] sum, nsum;

    display_mux #(.DIG_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .s(s), .en0_n(en0_n), .en1_n(en1_n), .sum(sum)
    );

    display_mux #(.DIG_CYCLES(4), .BLANK_CYCLES(0)) dut_nb (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .s(ns), .en0_n(nen0_n), .en1_n(nen1_n), .sum(nsum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        bit         chk_disp;
        digit_t     s;
        logic       e0, e1;
        digit_t     ns;
        logic       ne0, ne1;
        bit         chk_sum;
        logic [4:0] sum;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input int tag, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, tag, act, req);
        end
    endtask

    // Monitor: compares every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                cmp("missed_slot", e.cyc, 8'(cyc), 8'(e.cyc));
            end else begin
                if (e.chk_disp) begin
                    cmp("s",      e.cyc, 8'(s),      8'(e.s));
                    cmp("en0_n",  e.cyc, 8'(en0_n),  8'(e.e0));
                    cmp("en1_n",  e.cyc, 8'(en1_n),  8'(e.e1));
                    cmp("nb_s",   e.cyc, 8'(ns),     8'(e.ns));
                    cmp("nb_en0", e.cyc, 8'(nen0_n), 8'(e.ne0));
                    cmp("nb_en1", e.cyc, 8'(nen1_n), 8'(e.ne1));
                end
                if (e.chk_sum) cmp("sum", e.cyc, 8'(sum), 8'(e.sum));
            end
        end
        // Both enables low at once is illegal in every configuration.
        if (cyc > 0) begin
            if ((en0_n | en1_n) !== 1'b1)   cmp("overlap",    cyc, 8'(en0_n | en1_n), 8'd1);
            if ((nen0_n | nen1_n) !== 1'b1) cmp("nb_overlap", cyc, 8'(nen0_n | nen1_n), 8'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit cd, input digit_t es, input logic e0, input logic e1,
                        input digit_t ens, input logic ne0, input logic ne1,
                        input bit cs, input logic [4:0] esum);
        exp_t e;
        e.cyc = cyc + 1; e.chk_disp = cd;
        e.s = es; e.e0 = e0; e.e1 = e1;
        e.ns = ens; e.ne0 = ne0; e.ne1 = ne1;
        e.chk_sum = cs; e.sum = esum;
        q.push_back(e);
    endtask

    task automatic expect_idle();
        push(1'b1, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 5'h00);
    endtask

    // Releases reset with a=A, b=3 and follows n cycles of the sequence.
    // Main period is 12 (4 lit, 2 dark, 4 lit, 2 dark); no-blank period is 8.
    task automatic run_seq(input int n, input int chg_at);
        digit_t ms, nbs;
        int p, r;
        ms = 4'h0; nbs = 4'h0;
        a = 4'hA; b = 4'h3; reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            p = i % 12;
            r = i % 8;
            if (p == 0) ms = a;
            if (p == 6) ms = b;
            if (r == 0) nbs = a;
            if (r == 4) nbs = b;
            push(1'b1, ms, !(p < 4), !(p >= 6 && p < 10),
                 nbs, !(r < 4), !(r >= 4),
                 1'b1, {1'b0, a} + {1'b0, b});
            step();
            if (i == chg_at) a = 4'h7;
        end
    endtask

    initial begin
        reset = 1'b0; a = 4'h5; b = 4'h9;
        step();
        // Reset hold
        for (int i = 0; i < 3; i++) begin
            expect_idle();
            step();
        end
        // Normal sequence with a changed during DIG0 cycle 1
        run_seq(14, 1);
        // Re-run and abort at DIG1 cycle 2
        reset = 1'b0;
        expect_idle();
        step();
        run_seq(9, -1);
        reset = 1'b0;
        expect_idle();
        step();
        expect_idle();
        step();
        // Restart after abort must match the normal sequence
        run_seq(14, -1);
        // Sum corners
        a = 4'hF; b = 4'hF;
        push(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 5'h1E);
        step();
        a = 4'h0; b = 4'h0;
        push(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 5'h00);
        step();
        a = 4'h8; b = 4'h8;
        push(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 5'h10);
        step();
        step();
        step();
        cmp("queue_drained", cyc, 8'(q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
